// File: rtl/wb_trace_checker.sv
// wb_trace_checker
//   Compares the CPU write-back commit stream against a golden trace held in an
//   external combinational-read memory and reports a sticky pass/fail verdict.
//
//   Optional feature macro: TRACE_ERR_CAPTURE_EN
//     When defined, the first mismatch latches pc / expected / actual values.
//     When undefined, err_pc / err_expect / err_actual are tied to zero.
//
//   Ports
//     clk, rst_n                    clock, async active-low reset
//     start                         begin checking (only sampled in IDLE)
//     debug_wb_have_inst/pc/ena/reg/value   CPU retirement info
//     ref_idx                       golden trace address
//     ref_valid/pc/reg/value        golden entry at ref_idx (ref_valid=0 => end)
//     pass, fail, timeout           sticky verdicts
//     check_count                   number of matched commits
//     err_pc, err_expect, err_actual   first-mismatch capture
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | checking commits against the golden trace
//   PASS  | trace completed (end marker or capacity), terminal
//   FAIL  | mismatch or timeout, terminal
module wb_trace_checker #(
    parameter int IDX_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             debug_wb_have_inst,
    input  logic [31:0]      debug_wb_pc,
    input  logic             debug_wb_ena,
    input  logic [4:0]       debug_wb_reg,
    input  logic [31:0]      debug_wb_value,
    output logic [IDX_W-1:0] ref_idx,
    input  logic             ref_valid,
    input  logic [31:0]      ref_pc,
    input  logic [4:0]       ref_reg,
    input  logic [31:0]      ref_value,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [IDX_W-1:0] check_count,
    output logic [31:0]      err_pc,
    output logic [31:0]      err_expect,
    output logic [31:0]      err_actual
);

    localparam int                 CNT_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]   LP_TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]   LP_IDX_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [IDX_W-1:0] r_count, w_count_nxt;
    logic [CNT_W-1:0] r_idle, w_idle_nxt;
    logic             r_pass, r_fail, r_timeout, w_timeout_nxt;
    logic             w_commit, w_match;

    assign w_commit = debug_wb_have_inst && debug_wb_ena && (debug_wb_reg != 5'd0);
    assign w_match  = (debug_wb_pc == ref_pc) && (debug_wb_reg == ref_reg) &&
                      (debug_wb_value == ref_value);

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_count_nxt   = r_count;
        w_idle_nxt    = r_idle;
        w_timeout_nxt = r_timeout;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_idle_nxt  = '0;
                end
            end
            S_RUN: begin
                if (!ref_valid) begin
                    w_state_nxt = S_PASS;
                end else if (w_commit) begin
                    w_idle_nxt = '0;
                    if (w_match) begin
                        // count saturates: with a full trace it can exceed IDX_W bits by one
                        if (r_count != LP_IDX_MAX) w_count_nxt = r_count + 1'b1;
                        if (r_idx == LP_IDX_MAX) w_state_nxt = S_PASS;
                        else                     w_idx_nxt   = r_idx + 1'b1;
                    end else begin
                        w_state_nxt = S_FAIL;
                    end
                end else if (r_idle == LP_TO_LAST) begin
                    w_state_nxt   = S_FAIL;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_idle_nxt = r_idle + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_count   <= '0;
            r_idle    <= '0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_count   <= w_count_nxt;
            r_idle    <= w_idle_nxt;
            r_pass    <= (w_state_nxt == S_PASS);
            r_fail    <= (w_state_nxt == S_FAIL);
            r_timeout <= w_timeout_nxt;
        end
    end

    assign ref_idx     = r_idx;
    assign check_count = r_count;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;

`ifdef TRACE_ERR_CAPTURE_EN
    logic        w_capture;
    logic [31:0] r_err_pc, r_err_expect, r_err_actual;

    // only a mismatching commit captures; timeout leaves the registers at zero
    assign w_capture = (r_state == S_RUN) && ref_valid && w_commit && !w_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_pc     <= '0;
            r_err_expect <= '0;
            r_err_actual <= '0;
        end else if (w_capture) begin
            r_err_pc     <= debug_wb_pc;
            r_err_expect <= ref_value;
            r_err_actual <= debug_wb_value;
        end
    end

    assign err_pc     = r_err_pc;
    assign err_expect = r_err_expect;
    assign err_actual = r_err_actual;
`else
    assign err_pc     = '0;
    assign err_expect = '0;
    assign err_actual = '0;
`endif

endmodule

// File: tb/tb_wb_trace_checker.sv
module tb_wb_trace_checker;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst2_n, start;
    logic        have, ena;
    logic [4:0]  wreg;
    logic [31:0] pc, val;

    logic [15:0] ref_idx;
    logic        ref_valid;
    logic [31:0] ref_pc, ref_value;
    logic [4:0]  ref_reg;
    logic        pass, fail, tmo;
    logic [15:0] count;
    logic [31:0] err_pc, err_expect, err_actual;

    logic [1:0]  ref_idx2;
    logic        ref_valid2;
    logic [31:0] ref_pc2, ref_value2;
    logic [4:0]  ref_reg2;
    logic        pass2, fail2, tmo2;
    logic [1:0]  count2;
    logic [31:0] err_pc2, err_expect2, err_actual2;

    logic [31:0] g_pc [8];
    logic [31:0] g_val[8];
    logic [4:0]  g_reg[8];
    logic [15:0] g_len;
    logic [31:0] g2_pc [4];
    logic [31:0] g2_val[4];
    logic [4:0]  g2_reg[4];

    always_comb begin
        ref_valid = (ref_idx < g_len);
        ref_pc    = g_pc[ref_idx[2:0]];
        ref_reg   = g_reg[ref_idx[2:0]];
        ref_value = g_val[ref_idx[2:0]];
        ref_pc2    = g2_pc[ref_idx2];
        ref_reg2   = g2_reg[ref_idx2];
        ref_value2 = g2_val[ref_idx2];
    end
    assign ref_valid2 = 1'b1;

    wb_trace_checker #(.IDX_W(16), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .debug_wb_have_inst(have), .debug_wb_pc(pc), .debug_wb_ena(ena),
        .debug_wb_reg(wreg), .debug_wb_value(val),
        .ref_idx(ref_idx), .ref_valid(ref_valid), .ref_pc(ref_pc),
        .ref_reg(ref_reg), .ref_value(ref_value),
        .pass(pass), .fail(fail), .timeout(tmo), .check_count(count),
        .err_pc(err_pc), .err_expect(err_expect), .err_actual(err_actual)
    );

    wb_trace_checker #(.IDX_W(2), .TIMEOUT(16)) dut2 (
        .clk(clk), .rst_n(rst2_n), .start(start),
        .debug_wb_have_inst(have), .debug_wb_pc(pc), .debug_wb_ena(ena),
        .debug_wb_reg(wreg), .debug_wb_value(val),
        .ref_idx(ref_idx2), .ref_valid(ref_valid2), .ref_pc(ref_pc2),
        .ref_reg(ref_reg2), .ref_value(ref_value2),
        .pass(pass2), .fail(fail2), .timeout(tmo2), .check_count(count2),
        .err_pc(err_pc2), .err_expect(err_expect2), .err_actual(err_actual2)
    );

    typedef struct {
        string       tag;
        logic        p;
        logic        f;
        logic        t;
        logic [15:0] cnt;
        logic [15:0] idx;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic p, input logic f, input logic t,
                        input logic [15:0] cnt, input logic [15:0] idx);
        exp_t e;
        e.tag = tag; e.p = p; e.f = f; e.t = t; e.cnt = cnt; e.idx = idx;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $error("FAIL sb_empty: observed empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".pass"},    32'(pass),    32'(e.p));
        chk({e.tag, ".fail"},    32'(fail),    32'(e.f));
        chk({e.tag, ".timeout"}, 32'(tmo),     32'(e.t));
        chk({e.tag, ".count"},   32'(count),   32'(e.cnt));
        chk({e.tag, ".ref_idx"}, 32'(ref_idx), 32'(e.idx));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic h, input logic e, input logic [4:0] r,
                         input logic [31:0] p, input logic [31:0] v);
        have = h; ena = e; wreg = r; pc = p; val = v;
    endtask

    task automatic commit(input logic [4:0] r, input logic [31:0] p, input logic [31:0] v);
        drive(1'b1, 1'b1, r, p, v);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0; start = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            g_pc[i] = 32'h0; g_val[i] = 32'h0; g_reg[i] = 5'd0;
        end
        g_pc[0] = 32'h0; g_reg[0] = 5'd1; g_val[0] = 32'd5;
        g_pc[1] = 32'h4; g_reg[1] = 5'd2; g_val[1] = 32'd7;
        g_pc[2] = 32'h8; g_reg[2] = 5'd3; g_val[2] = 32'd12;
        g_len = 16'd3;
        for (int i = 0; i < 4; i++) begin
            g2_pc[i] = 32'h100 + 32'(i * 4); g2_reg[i] = 5'(i + 4); g2_val[i] = 32'(i + 40);
        end

        // reset state and idle hold without start
        tick(); tick();
        push("reset", 0, 0, 0, 0, 0); check_pop();
        chk("reset.err_pc", err_pc, 32'h0);
        rst_n = 1'b1;
        tick(); tick(); tick();
        push("idle_hold", 0, 0, 0, 0, 0); check_pop();

        // matching 3-entry trace
        go();
        commit(5'd1, 32'h0, 32'd5);
        commit(5'd2, 32'h4, 32'd7);
        commit(5'd3, 32'h8, 32'd12);
        push("t1_idx3", 0, 0, 0, 3, 3); check_pop();
        tick();
        push("t1_pass", 1, 0, 0, 3, 3); check_pop();
        go();
        push("t1_terminal", 1, 0, 0, 3, 3); check_pop();

        // mismatch on second commit
        do_reset();
        go();
        commit(5'd1, 32'h0, 32'd5);
        commit(5'd2, 32'h4, 32'd8);
        push("t2_fail", 0, 1, 0, 1, 1); check_pop();
`ifdef TRACE_ERR_CAPTURE_EN
        chk("t2.err_pc", err_pc, 32'h4);
        chk("t2.err_expect", err_expect, 32'h7);
        chk("t2.err_actual", err_actual, 32'h8);
`else
        chk("t2.err_pc", err_pc, 32'h0);
        chk("t2.err_expect", err_expect, 32'h0);
        chk("t2.err_actual", err_actual, 32'h0);
`endif
        commit(5'd2, 32'h4, 32'd7);
        push("t2_terminal", 0, 1, 0, 1, 1); check_pop();

        // x0 writes and non-writing retirements interleaved
        do_reset();
        go();
        commit(5'd0, 32'h100, 32'd99);
        drive(1'b1, 1'b0, 5'd5, 32'h104, 32'd1); tick();
        commit(5'd1, 32'h0, 32'd5);
        drive(1'b0, 1'b1, 5'd2, 32'h4, 32'd9); tick();
        commit(5'd2, 32'h4, 32'd7);
        commit(5'd0, 32'h8, 32'd0);
        push("t3_mid", 0, 0, 0, 2, 2); check_pop();
        commit(5'd3, 32'h8, 32'd12);
        tick();
        push("t3_pass", 1, 0, 0, 3, 3); check_pop();

        // timeout after 16 RUN cycles without a commit
        do_reset();
        go();
        repeat (15) tick();
        push("t4_before", 0, 0, 0, 0, 0); check_pop();
        tick();
        push("t4_timeout", 0, 1, 1, 0, 0); check_pop();
        chk("t4.err_actual", err_actual, 32'h0);

        // commit on the expiring cycle is checked instead of timing out
        do_reset();
        go();
        repeat (15) tick();
        commit(5'd1, 32'h0, 32'd5);
        push("t4_commit15", 0, 0, 0, 1, 1); check_pop();

        // asynchronous reset mid-RUN
        do_reset();
        go();
        commit(5'd1, 32'h0, 32'd5);
        commit(5'd2, 32'h4, 32'd7);
        push("t5_idx2", 0, 0, 0, 2, 2); check_pop();
        rst_n = 1'b0;
        #1;
        push("t5_async", 0, 0, 0, 0, 0); check_pop();
        tick();
        rst_n = 1'b1;
        commit(5'd1, 32'h0, 32'd5);
        tick();
        push("t5_idle", 0, 0, 0, 0, 0); check_pop();
        go();
        commit(5'd1, 32'h0, 32'd5);
        push("t5_resume", 0, 0, 0, 1, 1); check_pop();

        // 2-bit index: four matches exhaust capacity without wrapping
        rst2_n = 1'b1;
        tick();
        go();
        for (int i = 0; i < 3; i++) commit(g2_reg[i], g2_pc[i], g2_val[i]);
        chk("t6.idx_after3", 32'(ref_idx2), 32'd3);
        chk("t6.pass_after3", 32'(pass2), 32'd0);
        commit(g2_reg[3], g2_pc[3], g2_val[3]);
        chk("t6.pass", 32'(pass2), 32'd1);
        chk("t6.fail", 32'(fail2), 32'd0);
        chk("t6.idx", 32'(ref_idx2), 32'd3);
        tick();
        chk("t6.idx_hold", 32'(ref_idx2), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
